// File: rtl/console_pkg.sv
// Shared definitions for the console transmitter: default bus addresses,
// status word bit positions and the transmit state encoding.
package console_pkg;

  localparam logic [7:0] TX_ADDR_DEFAULT     = 8'hFF;
  localparam logic [7:0] STATUS_ADDR_DEFAULT = 8'hFE;

  localparam int ST_ACTIVE    = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO. Head entry is visible combinationally on dout.
// A push while full is ignored here; the caller decides what that means.
// Ports:
//   clock, clear   - rising-edge clock, synchronous active-high reset
//   push, din      - write strobe and data
//   pop, dout      - read strobe and head entry
//   count          - number of stored entries (0..DEPTH)
//   full, empty    - derived from count
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr];

  // Storage has no reset; entries are only observed once written.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/console_uart_tx.sv
// Memory-mapped console transmitter: bytes stored to TX_ADDR are queued
// and sent as UART 8N1 on tx; STATUS_ADDR exposes FIFO and line state.
// Ports:
//   clock, clear      - rising-edge clock, synchronous active-high reset
//   addr, wren, din   - store bus (only din[7:0] is used)
//   rden, rd_data     - status read request and registered status word
//   tx                - serial line, idle high
//   full              - FIFO full
//   irq_empty         - FIFO empty and line idle
//
// state | meaning
// IDLE  | line high; pops the head byte when the FIFO is non-empty
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high) for CLKS_PER_BIT cycles
module console_uart_tx
  import console_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] TX_ADDR      = TX_ADDR_DEFAULT,
  parameter logic [7:0] STATUS_ADDR  = STATUS_ADDR_DEFAULT
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [7:0]  addr,
  input  logic        wren,
  input  logic [31:0] din,
  input  logic        rden,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        full,
  output logic        irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  txState_t      stateCur, stateNext;
  logic [BW-1:0] baudCnt, baudNext;
  logic [2:0]    bitIdx, bitNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          txNext;
  logic          fifoPop;
  logic [7:0]    fifoDout;
  logic [CW-1:0] fifoCount;
  logic          fifoEmpty;
  logic          pushReq;
  logic          overflow;
  logic [31:0]   statusWord;
  logic          unusedDinBits;

  assign unusedDinBits = ^din[31:8];
  assign pushReq       = wren && (addr == TX_ADDR);
  assign irq_empty     = fifoEmpty && (stateCur == IDLE);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clock (clock),
    .clear (clear),
    .push  (pushReq),
    .din   (din[7:0]),
    .pop   (fifoPop),
    .dout  (fifoDout),
    .count (fifoCount),
    .full  (full),
    .empty (fifoEmpty)
  );

  // Overflow is sticky until software writes the status address. A push
  // that finds the FIFO full is dropped even if a pop lands in that cycle.
  always_ff @(posedge clock) begin
    if (clear)                                overflow <= 1'b0;
    else if (wren && (addr == STATUS_ADDR))   overflow <= 1'b0;
    else if (pushReq && full)                 overflow <= 1'b1;
  end

  always_comb begin
    statusWord                        = '0;
    statusWord[ST_ACTIVE]             = (stateCur != IDLE);
    statusWord[ST_EMPTY]              = fifoEmpty;
    statusWord[ST_FULL]               = full;
    statusWord[ST_OVF]                = overflow;
    statusWord[ST_COUNT_LSB +: 5]     = 5'(fifoCount);
  end

  always_ff @(posedge clock) begin
    if (clear)                               rd_data <= '0;
    else if (rden && (addr == STATUS_ADDR))  rd_data <= statusWord;
    else                                     rd_data <= '0;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      stateCur <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      tx       <= 1'b1;
    end else begin
      stateCur <= stateNext;
      baudCnt  <= baudNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
      tx       <= txNext;
    end
  end

  // tx is registered from the next-state view so the pin never glitches.
  always_comb begin
    stateNext = stateCur;
    baudNext  = baudCnt;
    bitNext   = bitIdx;
    shiftNext = shiftReg;
    fifoPop   = 1'b0;
    txNext    = 1'b1;
    case (stateCur)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          shiftNext = fifoDout;
          baudNext  = BAUD_LOAD;
          stateNext = START;
        end
      end
      START: begin
        if (baudCnt == '0) begin
          baudNext  = BAUD_LOAD;
          bitNext   = 3'd0;
          stateNext = DATA;
        end else begin
          baudNext = baudCnt - 1'b1;
        end
      end
      DATA: begin
        if (baudCnt == '0) begin
          baudNext  = BAUD_LOAD;
          shiftNext = {1'b0, shiftReg[7:1]};
          if (bitIdx == 3'd7) stateNext = STOP;
          else                bitNext   = bitIdx + 3'd1;
        end else begin
          baudNext = baudCnt - 1'b1;
        end
      end
      STOP: begin
        if (baudCnt == '0) stateNext = IDLE;
        else               baudNext  = baudCnt - 1'b1;
      end
      default: stateNext = IDLE;
    endcase
    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[0];
      default: txNext = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_console_uart_tx.sv
module tb_console_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [7:0]  addr  = 8'h00;
  logic        wren  = 1'b0;
  logic [31:0] din   = 32'h0;
  logic        rden  = 1'b0;
  logic [31:0] rd_data;
  logic        tx;
  logic        full;
  logic        irq_empty;

  console_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .TX_ADDR      (8'hFF),
    .STATUS_ADDR  (8'hFE)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .addr      (addr),
    .wren      (wren),
    .din       (din),
    .rden      (rden),
    .rd_data   (rd_data),
    .tx        (tx),
    .full      (full),
    .irq_empty (irq_empty)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int frames = 0;
  int storeCyc = 0;

  logic [7:0]  expQ[$];
  logic [31:0] rdQ[$];
  int          fallQ[$];

  bit rdFlag    = 0;
  bit rdLatched = 0;

  always @(posedge clock) begin
    cyc++;
    rdLatched = rdFlag;
  end

  // Status read monitor: compares rd_data after every edge.
  always @(negedge clock) begin
    logic [31:0] e;
    if (rdLatched) begin
      checks++;
      if (rdQ.size() == 0) begin
        errors++;
        $display("FAIL rdUnexpected got=%h", rd_data);
      end else begin
        e = rdQ.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rdStatus got=%h exp=%h", rd_data, e);
        end
      end
    end else begin
      checks++;
      if (rd_data !== 32'h0) begin
        errors++;
        $display("FAIL rdIdleZero got=%h exp=00000000", rd_data);
      end
    end
  end

  // UART receiver monitor: captures every cycle of a frame.
  logic        prevTx = 1'b1;
  bit          inFrame = 0;
  int          pos = 0;
  logic [FRAME-1:0] samp;

  task automatic checkFrame();
    logic [7:0] b;
    logic [7:0] e;
    bit ok = 1;
    for (int k = 0; k < 10; k++)
      for (int j = 1; j < CPB; j++)
        if (samp[k*CPB+j] !== samp[k*CPB]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bitTiming frame=%0d line=%b exp=constant per bit", frames, samp);
    end
    checks++;
    if (samp[0] !== 1'b0 || samp[9*CPB] !== 1'b1) begin
      errors++;
      $display("FAIL framing start=%b stop=%b exp start=0 stop=1", samp[0], samp[9*CPB]);
    end
    for (int i = 0; i < 8; i++) b[i] = samp[(i+1)*CPB];
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL unexpectedFrame got=%h exp=none", b);
    end else begin
      e = expQ.pop_front();
      if (b !== e) begin
        errors++;
        $display("FAIL frameData got=%h exp=%h", b, e);
      end
    end
    frames++;
  endtask

  always @(negedge clock) begin
    if (clear) begin
      inFrame = 0;
    end else if (inFrame) begin
      samp[pos] = tx;
      pos++;
      if (pos == FRAME) begin
        inFrame = 0;
        checkFrame();
      end
    end else if (prevTx === 1'b1 && tx === 1'b0) begin
      inFrame = 1;
      samp[0] = tx;
      pos = 1;
      fallQ.push_back(cyc);
    end
    prevTx = tx;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic store(input logic [7:0] a, input logic [7:0] d, input bit accepted);
    addr = a;
    din  = {24'hA5A5A5, d};
    wren = 1'b1;
    if (accepted) expQ.push_back(d);
    @(posedge clock); #1;
    wren = 1'b0;
    storeCyc = cyc;
  endtask

  task automatic doRead(input logic [7:0] a, input logic [31:0] exp);
    addr   = a;
    rden   = 1'b1;
    rdFlag = 1;
    rdQ.push_back(exp);
    @(posedge clock); #1;
    rden   = 1'b0;
    rdFlag = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic waitFrames(input int n, input int budget);
    int k = 0;
    while (frames < n && k < budget) begin
      @(posedge clock);
      k++;
    end
    #1;
    checks++;
    if (frames < n) begin
      errors++;
      $display("FAIL frameTimeout got=%0d exp=%0d", frames, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge clock);
    #1;
    clear = 1'b0;
    check("resetTx", {31'b0, tx}, 32'h1);
    check("resetIrq", {31'b0, irq_empty}, 32'h1);
    check("resetFull", {31'b0, full}, 32'h0);
    check("resetRd", rd_data, 32'h0);

    doRead(8'hFE, 32'h0000_0002);
    idle(2);

    // Single byte: fall one edge after the store edge
    store(8'hFF, 8'h41, 1);
    k = 0;
    while (fallQ.size() == 0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (fallQ.size() == 0) begin
      errors++;
      $display("FAIL txFallTimeout got=none exp=fall");
    end else begin
      check("txFallLatency", fallQ[0], storeCyc + 1);
    end
    @(posedge clock); #1;
    doRead(8'hFE, 32'h0000_0003);
    waitFrames(1, 60);
    idle(3);
    check("idleTx", {31'b0, tx}, 32'h1);
    check("idleIrq", {31'b0, irq_empty}, 32'h1);

    // Back-to-back
    fallQ.delete();
    store(8'hFF, 8'h55, 1);
    store(8'hFF, 8'hAA, 1);
    waitFrames(3, 200);
    checks++;
    if (fallQ.size() < 2) begin
      errors++;
      $display("FAIL b2bFalls got=%0d exp=2", fallQ.size());
    end else begin
      check("b2bGap", fallQ[1] - fallQ[0], FRAME + 1);
    end
    idle(3);

    // Overflow: 9 accepted (one popped immediately), 10th dropped
    for (int i = 0; i < 10; i++)
      store(8'hFF, 8'h10 + 8'(i), i < 9);
    check("ovfFull", {31'b0, full}, 32'h1);
    doRead(8'hFE, 32'h0000_080D);
    store(8'hFE, 8'h00, 0);
    doRead(8'hFE, 32'h0000_0805);
    waitFrames(12, 600);
    idle(3);
    check("afterOvfIrq", {31'b0, irq_empty}, 32'h1);

    // Address filter
    store(8'hFD, 8'h33, 0);
    store(8'h00, 8'h44, 0);
    doRead(8'hFF, 32'h0);
    doRead(8'hFD, 32'h0);
    idle(20);
    check("filterFrames", frames, 12);
    check("filterTx", {31'b0, tx}, 32'h1);
    check("filterIrq", {31'b0, irq_empty}, 32'h1);

    // Reset mid-frame with 3 bytes queued
    for (int i = 0; i < 4; i++) store(8'hFF, 8'hC0 + 8'(i), 1);
    idle(10);
    expQ.delete();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    check("rstTx", {31'b0, tx}, 32'h1);
    check("rstIrq", {31'b0, irq_empty}, 32'h1);
    check("rstRd", rd_data, 32'h0);
    check("rstFull", {31'b0, full}, 32'h0);
    doRead(8'hFE, 32'h0000_0002);
    idle(100);
    check("rstNoFrames", frames, 12);
    check("rstTxHigh", {31'b0, tx}, 32'h1);
    check("expQDrained", expQ.size(), 0);
    check("rdQDrained", rdQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
